fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if_id_register.sv | 55 +++++
 rtl/fetch_stage.sv | 74 +++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared next-PC select encodings and fetch constants.
// Revision    : 1.0
// ============================================================================
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_JUMP2  = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INCREMENT     = 4;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : IF_ID_Register
// Description : IF/ID pipeline register; stall holds, clear loads a bubble.
// Revision    : 1.0
// ============================================================================
module IF_ID_Register
    import fetch_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pcplus4,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pcplus4,
    output logic             o_valid
);

    localparam logic [WIDTH-1:0] C_NOP = WIDTH'(NOP_INSTR);

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pcplus4;
    logic             r_valid;

    // Stall outranks clear: a held instruction must not be lost to a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= '0;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
        end else if (i_stall) begin
            r_instr   <= r_instr;
            r_pcplus4 <= r_pcplus4;
            r_valid   <= r_valid;
        end else if (i_clear) begin
            r_instr   <= C_NOP;
            r_pcplus4 <= i_pcplus4;
            r_valid   <= 1'b0;
        end else begin
            r_instr   <= i_instr;
            r_pcplus4 <= i_pcplus4;
            r_valid   <= 1'b1;
        end
    end

    assign o_instr   = r_instr;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;

endmodule : IF_ID_Register
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, next-PC selection and IF/ID pipeline register.
// Revision    : 1.0
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic [1:0]       PCSrcD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    logic [WIDTH-1:0] r_pcf;
    logic [WIDTH-1:0] w_pcplus4f;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_redirect;
    logic             w_clear_d;

    assign w_pcplus4f    = r_pcf + WIDTH'(PC_INCREMENT);
    // Pseudo-direct jump: region bits from the decode-stage PC+4.
    assign w_jump_target = {PCPlus4D[WIDTH-1:28], InstrD[25:0], 2'b00};
    assign w_redirect    = (PCSrcD != PCSRC_PLUS4);
    assign w_clear_d     = FlushD | w_redirect;

    always_comb begin
        w_next_pc = w_pcplus4f;
        case (PCSrcD)
            PCSRC_PLUS4:  w_next_pc = w_pcplus4f;
            PCSRC_BRANCH: w_next_pc = PCBranchD;
            default:      w_next_pc = w_jump_target;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pcf <= RESET_PC;
        end else if (!StallF) begin
            r_pcf <= w_next_pc;
        end
    end

    assign PCF = r_pcf;

    IF_ID_Register #(
        .WIDTH (WIDTH)
    ) u_if_id (
        .clk       (CLK),
        .rst_n     (RST),
        .i_stall   (StallD),
        .i_clear   (w_clear_d),
        .i_instr   (InstrF),
        .i_pcplus4 (w_pcplus4f),
        .o_instr   (InstrD),
        .o_pcplus4 (PCPlus4D),
        .o_valid   (ValidD)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed and randomized checks of fetch_stage against a model.
// Revision    : 1.0
// ============================================================================
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [1:0]  PCSrcD = 2'b00;
    logic [31:0] PCBranchD = '0;
    logic [31:0] InstrF = '0;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the fetch stage should present after each edge.
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".PCF"},      PCF,      m_pc);
        check({tag, ".InstrD"},   InstrD,   m_instr);
        check({tag, ".PCPlus4D"}, PCPlus4D, m_p4);
        check({tag, ".ValidD"},   {31'b0, ValidD}, {31'b0, m_valid});
    endtask

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return pc + 32'h100;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_p4    = 32'h0;
        m_valid = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must follow without an edge.
    task automatic async_reset(input string tag);
        @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic step(input string tag, input bit sf, input bit sd, input bit fl,
                        input logic [1:0] src, input logic [31:0] br,
                        input logic [31:0] instr);
        logic [31:0] seq, target, nxt;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fl;
        PCSrcD    = src;
        PCBranchD = br;
        InstrF    = instr;
        @(posedge CLK);
        seq    = m_pc + 32'd4;
        target = (m_p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        if (src == 2'b00)      nxt = seq;
        else if (src == 2'b01) nxt = br;
        else                   nxt = target;
        if (!sd) begin
            m_p4 = seq;
            if (fl || src != 2'b00) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else begin
                m_instr = instr;
                m_valid = 1'b1;
            end
        end
        if (!sf) m_pc = nxt;
        #1;
        check_all(tag);
    endtask

    task automatic go(input string tag);
        step(tag, 0, 0, 0, 2'b00, 32'h0, imem(m_pc));
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset_hold");
        @(negedge CLK);
        RST = 1'b1;

        // Straight-line fetch: PCF 4, 8, C with InstrD one cycle behind.
        go("first_edge");
        check("first_instr", InstrD, 32'h100);
        go("straight1");
        go("straight2");
        check("straight_pc", PCF, 32'hC);

        // Stall with both registers held, then resume at 0x10.
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 0, 2'b00, 32'h0, imem(m_pc));
        go("stall_release");
        check("resume_pc", PCF, 32'h10);

        // Branch from PCF=8.
        async_reset("reset_mid");
        go("b0");
        go("b1");
        step("branch", 0, 0, 0, 2'b01, 32'h40, imem(m_pc));
        check("branch_pc", PCF, 32'h40);
        check("branch_bubble", {31'b0, ValidD}, 32'h0);

        // Jump: InstrD=0x08000010 with PCPlus4D=0x24 targets 0x40.
        step("to20", 0, 0, 0, 2'b01, 32'h20, imem(m_pc));
        step("load_j", 0, 0, 0, 2'b00, 32'h0, 32'h0800_0010);
        step("jump", 0, 0, 0, 2'b10, 32'h0, imem(m_pc));
        check("jump_pc", PCF, 32'h40);
        step("load_j2", 0, 0, 0, 2'b00, 32'h0, 32'h0BAD_C0DE);
        step("jump11", 0, 0, 0, 2'b11, 32'h1234, imem(m_pc));

        // Stall-over-flush and redirect ignored under StallF.
        step("stall_flush", 0, 1, 1, 2'b00, 32'h0, imem(m_pc));
        step("redir_stallf", 1, 0, 0, 2'b01, 32'h80, imem(m_pc));

        // Wrap from the top of the address space.
        step("to_top", 0, 0, 0, 2'b01, 32'hFFFF_FFFC, imem(m_pc));
        go("wrap");
        check("wrap_pc", PCF, 32'h0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 60) == 0)
                async_reset("rand_reset");
            else
                step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0, src, $urandom & 32'hFFFF_FFFC, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
